// File: rtl/ctx_mem_arbiter_if.sv
// Signal bundle between the arbiter, its three requesters and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding environment's.
interface ctx_mem_arbiter_if;
   logic        core_req_i;
   logic        core_we_i;
   logic [3:0]  core_be_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wdata_i;
   logic        core_gnt_o;
   logic        core_rvalid_o;
   logic [31:0] core_rdata_o;

   logic        ctx_wr_valid_i;
   logic [31:0] ctx_wr_addr_i;
   logic [31:0] ctx_wr_data_i;
   logic        ctx_wr_ready_o;
   logic        ctx_rd_valid_i;
   logic [31:0] ctx_rd_addr_i;
   logic        ctx_rd_ready_o;
   logic        ctx_rd_resp_valid_o;
   logic [31:0] ctx_rd_resp_data_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o,
      input  ctx_wr_valid_i, ctx_wr_addr_i, ctx_wr_data_i,
      output ctx_wr_ready_o,
      input  ctx_rd_valid_i, ctx_rd_addr_i,
      output ctx_rd_ready_o, ctx_rd_resp_valid_o, ctx_rd_resp_data_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o,
      output ctx_wr_valid_i, ctx_wr_addr_i, ctx_wr_data_i,
      input  ctx_wr_ready_o,
      output ctx_rd_valid_i, ctx_rd_addr_i,
      input  ctx_rd_ready_o, ctx_rd_resp_valid_o, ctx_rd_resp_data_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/ctx_mem_arbiter.sv
// Shares one OBI data-memory port between the core and the RTOS context write/read channels,
// with grant-hold locking, in-order response routing and a bound on ctx starvation.
//
// state    | meaning
// ST_OPEN  | free to arbitrate among pending requests
// ST_HOLD  | request issued but not granted; selection frozen on lock_src_q
module ctx_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ctx_mem_arbiter_if.slave      bus,
   output logic                  busy_o,
   output logic                  err_o
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {SRC_CORE = 2'd0, SRC_WR = 2'd1, SRC_RD = 2'd2} src_e;
   typedef enum logic {ST_OPEN = 1'b0, ST_HOLD = 1'b1} state_e;

   state_e          state_q, state_d;
   src_e            lock_src_q, lock_src_d;
   logic [3:0]      starve_q, starve_d;
   logic            rr_q, rr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   src_e            fifo_q [MAX_OUTSTANDING];
   src_e            fifo_d [MAX_OUTSTANDING];

   src_e            sel;
   src_e            head;
   logic            req, fire, pop, ctx_any;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   assign ctx_any = bus.ctx_wr_valid_i | bus.ctx_rd_valid_i;
   assign head    = fifo_q[rd_ptr_q];
   assign fire    = req & bus.mem_gnt_i;
   assign pop     = bus.mem_rvalid_i & (cnt_q != '0);

   // Gating on rst_ni keeps every output low while reset is held, even with requests pending.
   always_comb begin
      sel = SRC_CORE;
      req = 1'b0;
      if (rst_ni) begin
         if (state_q == ST_HOLD) begin
            sel = lock_src_q;
            req = 1'b1;
         end else if (cnt_q != CW'(MAX_OUTSTANDING)) begin
            if (bus.core_req_i && (!ctx_any || starve_q < 4'(STARVE_LIMIT))) begin
               sel = SRC_CORE;
               req = 1'b1;
            end else if (ctx_any) begin
               req = 1'b1;
               if (bus.ctx_wr_valid_i && bus.ctx_rd_valid_i) sel = rr_q ? SRC_RD : SRC_WR;
               else if (bus.ctx_wr_valid_i)                  sel = SRC_WR;
               else                                          sel = SRC_RD;
            end
         end
      end
   end

   always_comb begin
      bus.mem_req_o   = req;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = 4'h0;
      bus.mem_addr_o  = 32'h0;
      bus.mem_wdata_o = 32'h0;
      if (req) begin
         unique case (sel)
            SRC_CORE: begin
               bus.mem_we_o    = bus.core_we_i;
               bus.mem_be_o    = bus.core_be_i;
               bus.mem_addr_o  = bus.core_addr_i;
               bus.mem_wdata_o = bus.core_wdata_i;
            end
            SRC_WR: begin
               bus.mem_we_o    = 1'b1;
               bus.mem_be_o    = 4'hF;
               bus.mem_addr_o  = bus.ctx_wr_addr_i;
               bus.mem_wdata_o = bus.ctx_wr_data_i;
            end
            default: begin
               bus.mem_be_o    = 4'hF;
               bus.mem_addr_o  = bus.ctx_rd_addr_i;
            end
         endcase
      end
      bus.core_gnt_o          = fire & (sel == SRC_CORE);
      bus.ctx_wr_ready_o      = fire & (sel == SRC_WR);
      bus.ctx_rd_ready_o      = fire & (sel == SRC_RD);
      bus.core_rvalid_o       = pop & (head == SRC_CORE);
      bus.core_rdata_o        = (pop && head == SRC_CORE) ? bus.mem_rdata_i : 32'h0;
      bus.ctx_rd_resp_valid_o = pop & (head == SRC_RD);
      bus.ctx_rd_resp_data_o  = (pop && head == SRC_RD) ? bus.mem_rdata_i : 32'h0;
      busy_o                  = (state_q == ST_HOLD) | (cnt_q != '0);
      err_o                   = err_q;
   end

   always_comb begin
      state_d    = (req && !bus.mem_gnt_i) ? ST_HOLD : ST_OPEN;
      lock_src_d = (req && !bus.mem_gnt_i) ? sel : lock_src_q;
      rr_d       = rr_q ^ (fire && sel != SRC_CORE);
      starve_d   = starve_q;
      if ((fire && sel != SRC_CORE) || !ctx_any) starve_d = 4'h0;
      else if (fire)
         starve_d = (starve_q >= 4'(STARVE_LIMIT)) ? 4'(STARVE_LIMIT) : starve_q + 4'h1;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (fire) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (fire && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!fire && pop) cnt_d = cnt_q - CW'(1);
      err_d = err_q | (bus.mem_rvalid_i & (cnt_q == '0));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_OPEN;
         lock_src_q <= SRC_CORE;
         starve_q   <= 4'h0;
         rr_q       <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         fifo_q     <= '{default: SRC_CORE};
      end else begin
         state_q    <= state_d;
         lock_src_q <= lock_src_d;
         starve_q   <= starve_d;
         rr_q       <= rr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         fifo_q     <= fifo_d;
      end
   end
endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Bench for ctx_mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_ctx_mem_arbiter;
   localparam int MAXO = 2;
   localparam int LIM  = 4;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic busy_o, err_o;

   ctx_mem_arbiter_if bus();

   ctx_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus.slave),
      .busy_o(busy_o),
      .err_o (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        creq;
      logic        cwe;
      logic [3:0]  cbe;
      logic [31:0] caddr;
      logic [31:0] cwdata;
      logic        wrv;
      logic [31:0] wra;
      logic [31:0] wrd;
      logic        rdv;
      logic [31:0] rda;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
   } in_t;

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        cgnt;
      logic        wrr;
      logic        rdr;
      logic        crv;
      logic        rrv;
      logic [31:0] data;
      logic        busy;
      logic        err;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   int vec_cnt = 0;
   int mis_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t I(input logic creq, input logic wrv, input logic rdv, input logic gnt,
                             input logic rv, input logic [31:0] caddr, input logic [31:0] rdata);
      in_t v;
      v.rst = 1'b1;   v.creq = creq; v.cwe = 1'b0; v.cbe = 4'h3;
      v.caddr = caddr; v.cwdata = 32'h11;
      v.wrv = wrv;    v.wra = 32'h2000; v.wrd = 32'h55;
      v.rdv = rdv;    v.rda = 32'h3000;
      v.gnt = gnt;    v.rv = rv; v.rdata = rdata;
      return v;
   endfunction

   function automatic exp_t E(input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic cgnt, input logic wrr, input logic rdr,
                              input logic crv, input logic rrv, input logic [31:0] data,
                              input logic busy, input logic err);
      exp_t e;
      e.req = req; e.we = we; e.be = be; e.addr = addr; e.wdata = wdata;
      e.cgnt = cgnt; e.wrr = wrr; e.rdr = rdr; e.crv = crv; e.rrv = rrv;
      e.data = data; e.busy = busy; e.err = err;
      return e;
   endfunction

   task automatic drive(input in_t v);
      rst_ni               = v.rst;
      bus.core_req_i       = v.creq;
      bus.core_we_i        = v.cwe;
      bus.core_be_i        = v.cbe;
      bus.core_addr_i      = v.caddr;
      bus.core_wdata_i     = v.cwdata;
      bus.ctx_wr_valid_i   = v.wrv;
      bus.ctx_wr_addr_i    = v.wra;
      bus.ctx_wr_data_i    = v.wrd;
      bus.ctx_rd_valid_i   = v.rdv;
      bus.ctx_rd_addr_i    = v.rda;
      bus.mem_gnt_i        = v.gnt;
      bus.mem_rvalid_i     = v.rv;
      bus.mem_rdata_i      = v.rdata;
   endtask

   task automatic check_exp(input exp_t e, input string tag);
      chk({tag, ".mem_req"}, {31'b0, bus.mem_req_o}, {31'b0, e.req});
      if (e.req) begin
         chk({tag, ".mem_we"},    {31'b0, bus.mem_we_o}, {31'b0, e.we});
         chk({tag, ".mem_be"},    {28'b0, bus.mem_be_o}, {28'b0, e.be});
         chk({tag, ".mem_addr"},  bus.mem_addr_o,  e.addr);
         chk({tag, ".mem_wdata"}, bus.mem_wdata_o, e.wdata);
      end
      chk({tag, ".core_gnt"},     {31'b0, bus.core_gnt_o},          {31'b0, e.cgnt});
      chk({tag, ".wr_ready"},     {31'b0, bus.ctx_wr_ready_o},      {31'b0, e.wrr});
      chk({tag, ".rd_ready"},     {31'b0, bus.ctx_rd_ready_o},      {31'b0, e.rdr});
      chk({tag, ".core_rvalid"},  {31'b0, bus.core_rvalid_o},       {31'b0, e.crv});
      chk({tag, ".rd_resp_valid"},{31'b0, bus.ctx_rd_resp_valid_o}, {31'b0, e.rrv});
      if (e.crv) chk({tag, ".core_rdata"},   bus.core_rdata_o,       e.data);
      if (e.rrv) chk({tag, ".rd_resp_data"}, bus.ctx_rd_resp_data_o, e.data);
      chk({tag, ".busy"}, {31'b0, busy_o}, {31'b0, e.busy});
      chk({tag, ".err"},  {31'b0, err_o},  {31'b0, e.err});
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      drive(v.i);
      @(negedge clk_i);
      check_exp(v.e, tag);
      @(posedge clk_i);
      #1;
   endtask

   // Reset pulse with every requester and the memory shouting: all outputs must stay low.
   task automatic do_reset();
      vec_t v;
      v.i     = I(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h800, 32'h5);
      v.i.rst = 1'b0;
      v.e     = E(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vec(v, "reset");
   endtask

   // ---------------- reference model ----------------
   bit  m_lock;
   int  m_lsrc;
   int  m_starve;
   bit  m_rr;
   int  m_q[$];
   bit  m_err;

   task automatic model_clear();
      m_lock = 0; m_lsrc = 0; m_starve = 0; m_rr = 0; m_err = 0;
      m_q.delete();
   endtask

   task automatic model_eval(input in_t v, output bit req, output int src, output exp_t e);
      bit ctx;
      req = 0; src = 0;
      e = E(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (!v.rst) return;
      ctx = v.wrv || v.rdv;
      if (m_lock) begin
         req = 1; src = m_lsrc;
      end else if (m_q.size() < MAXO) begin
         if (v.creq && (!ctx || m_starve < LIM)) begin
            req = 1; src = 0;
         end else if (v.wrv && v.rdv) begin
            req = 1; src = m_rr ? 2 : 1;
         end else if (ctx) begin
            req = 1; src = v.wrv ? 1 : 2;
         end
      end
      e.req = req;
      if (req) begin
         case (src)
            0:       begin e.we = v.cwe; e.be = v.cbe; e.addr = v.caddr; e.wdata = v.cwdata; end
            1:       begin e.we = 1'b1;  e.be = 4'hF;  e.addr = v.wra;   e.wdata = v.wrd;    end
            default: begin e.we = 1'b0;  e.be = 4'hF;  e.addr = v.rda;   e.wdata = 32'h0;    end
         endcase
      end
      e.cgnt = req && v.gnt && src == 0;
      e.wrr  = req && v.gnt && src == 1;
      e.rdr  = req && v.gnt && src == 2;
      if (v.rv && m_q.size() > 0) begin
         e.crv  = (m_q[0] == 0);
         e.rrv  = (m_q[0] == 2);
         e.data = v.rdata;
      end
      e.busy = m_lock || m_q.size() > 0;
      e.err  = m_err;
   endtask

   task automatic model_step(input in_t v, input bit req, input int src);
      if (!v.rst) begin
         model_clear();
         return;
      end
      if (v.rv) begin
         if (m_q.size() == 0) m_err = 1;
         else void'(m_q.pop_front());
      end
      if (req && v.gnt) m_q.push_back(src);
      if (req && !v.gnt) begin
         m_lock = 1; m_lsrc = src;
      end else m_lock = 0;
      if ((req && v.gnt && src != 0) || !(v.wrv || v.rdv)) m_starve = 0;
      else if (req && v.gnt) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      if (req && v.gnt && src != 0) m_rr = !m_rr;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[22];
      vec_t seq[8];
      int   cg;
      bit   rd_seen;

      drive(I(0, 0, 0, 0, 0, 0, 0));
      #1;
      do_reset();

      // Core read, ctx write with delayed grant, lock hold, in-order routing, ctx read.
      tbl[0]  = '{i: I(1,0,0,1,0,32'h100,0),        e: E(1,0,4'h3,32'h100,32'h11, 1,0,0, 0,0,0, 0,0)};
      tbl[1]  = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      tbl[2]  = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      tbl[3]  = '{i: I(0,0,0,0,1,0,32'hDEADBEEF),   e: E(0,0,0,0,0, 0,0,0, 1,0,32'hDEADBEEF, 1,0)};
      tbl[4]  = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      tbl[5]  = '{i: I(0,1,0,0,0,0,0),              e: E(1,1,4'hF,32'h2000,32'h55, 0,0,0, 0,0,0, 0,0)};
      tbl[6]  = '{i: I(0,1,0,0,0,0,0),              e: E(1,1,4'hF,32'h2000,32'h55, 0,0,0, 0,0,0, 1,0)};
      tbl[7]  = '{i: I(0,1,0,0,0,0,0),              e: E(1,1,4'hF,32'h2000,32'h55, 0,0,0, 0,0,0, 1,0)};
      tbl[8]  = '{i: I(0,1,0,1,0,0,0),              e: E(1,1,4'hF,32'h2000,32'h55, 0,1,0, 0,0,0, 1,0)};
      tbl[9]  = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      tbl[10] = '{i: I(0,0,0,0,1,0,32'h77),         e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      tbl[11] = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      tbl[12] = '{i: I(1,0,0,0,0,32'h400,0),        e: E(1,0,4'h3,32'h400,32'h11, 0,0,0, 0,0,0, 0,0)};
      tbl[13] = '{i: I(1,1,0,0,0,32'h400,0),        e: E(1,0,4'h3,32'h400,32'h11, 0,0,0, 0,0,0, 1,0)};
      tbl[14] = '{i: I(1,1,0,1,0,32'h400,0),        e: E(1,0,4'h3,32'h400,32'h11, 1,0,0, 0,0,0, 1,0)};
      tbl[15] = '{i: I(0,1,0,1,0,0,0),              e: E(1,1,4'hF,32'h2000,32'h55, 0,1,0, 0,0,0, 1,0)};
      tbl[16] = '{i: I(0,0,0,0,1,0,32'hA),          e: E(0,0,0,0,0, 0,0,0, 1,0,32'hA, 1,0)};
      tbl[17] = '{i: I(0,0,0,0,1,0,32'hB),          e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      tbl[18] = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      tbl[19] = '{i: I(0,0,1,1,0,0,0),              e: E(1,0,4'hF,32'h3000,32'h0, 0,0,1, 0,0,0, 0,0)};
      tbl[20] = '{i: I(0,0,0,0,1,0,32'hC),          e: E(0,0,0,0,0, 0,0,0, 0,1,32'hC, 1,0)};
      tbl[21] = '{i: I(0,0,0,0,0,0,0),              e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      for (int k = 0; k < 22; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

      // Starvation: core hammers, RD waits; exactly LIM core grants then RD.
      do_reset();
      cg = 0;
      rd_seen = 0;
      for (int c = 0; c < 12 && !rd_seen; c++) begin
         drive(I(1, 0, 1, 1, c > 0, 32'h500, 32'h1));
         @(negedge clk_i);
         if (bus.core_gnt_o === 1'b1) cg++;
         if (bus.ctx_rd_ready_o === 1'b1) rd_seen = 1;
         @(posedge clk_i);
         #1;
      end
      chk("starve_core_grants", 32'(cg), 32'(LIM));
      chk("starve_rd_granted", {31'b0, rd_seen}, 32'd1);
      drive(I(1, 0, 1, 1, 1, 32'h500, 32'h1));
      @(negedge clk_i);
      chk("starve_cleared_core_gnt", {31'b0, bus.core_gnt_o}, 32'd1);
      chk("starve_cleared_rd_ready", {31'b0, bus.ctx_rd_ready_o}, 32'd0);
      @(posedge clk_i);
      #1;

      // Ordering with a full FIFO.
      do_reset();
      seq[0] = '{i: I(1,0,0,1,0,32'h600,0),   e: E(1,0,4'h3,32'h600,32'h11, 1,0,0, 0,0,0, 0,0)};
      seq[1] = '{i: I(0,0,1,1,0,0,0),         e: E(1,0,4'hF,32'h3000,32'h0, 0,0,1, 0,0,0, 1,0)};
      seq[2] = '{i: I(1,0,0,1,0,32'h600,0),   e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      seq[3] = '{i: I(1,0,0,1,1,32'h600,32'hA), e: E(0,0,0,0,0, 0,0,0, 1,0,32'hA, 1,0)};
      seq[4] = '{i: I(1,0,0,0,1,32'h600,32'hB), e: E(1,0,4'h3,32'h600,32'h11, 0,0,0, 0,1,32'hB, 1,0)};
      for (int k = 0; k < 5; k++) run_vec(seq[k], $sformatf("order%0d", k));

      // Stray rvalid right after reset, then after a reset that drops an outstanding read.
      do_reset();
      seq[0] = '{i: I(0,0,0,0,1,0,32'h99),    e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      seq[1] = '{i: I(0,0,0,0,0,0,0),         e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,1)};
      seq[2] = '{i: I(0,0,0,0,0,0,0),         e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,1)};
      for (int k = 0; k < 3; k++) run_vec(seq[k], $sformatf("err%0d", k));
      do_reset();
      seq[0] = '{i: I(1,0,0,1,0,32'h700,0),   e: E(1,0,4'h3,32'h700,32'h11, 1,0,0, 0,0,0, 0,0)};
      seq[1] = '{i: I(0,0,0,0,0,0,0),         e: E(0,0,0,0,0, 0,0,0, 0,0,0, 1,0)};
      for (int k = 0; k < 2; k++) run_vec(seq[k], $sformatf("midrst%0d", k));
      do_reset();
      seq[0] = '{i: I(0,0,0,0,1,0,32'h42),    e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,0)};
      seq[1] = '{i: I(0,0,0,0,0,0,0),         e: E(0,0,0,0,0, 0,0,0, 0,0,0, 0,1)};
      for (int k = 0; k < 2; k++) run_vec(seq[k], $sformatf("midrst_err%0d", k));

      // Randomized traffic against the model; requesters hold until granted.
      do_reset();
      model_clear();
      begin
         in_t  cur;
         exp_t e;
         bit   req;
         int   src;
         bit   g_core, g_wr, g_rd;
         cur = I(0, 0, 0, 0, 0, 0, 0);
         for (int n = 0; n < 3000; n++) begin
            drive(cur);
            model_eval(cur, req, src, e);
            @(negedge clk_i);
            check_exp(e, "rand");
            @(posedge clk_i);
            model_step(cur, req, src);
            #1;
            g_core = e.cgnt;
            g_wr   = e.wrr;
            g_rd   = e.rdr;
            if (!(cur.creq && !g_core)) begin
               cur.creq   = ($urandom_range(0, 3) != 0);
               cur.cwe    = 1'($urandom_range(0, 1));
               cur.cbe    = 4'($urandom);
               cur.caddr  = $urandom;
               cur.cwdata = $urandom;
            end
            if (!(cur.wrv && !g_wr)) begin
               cur.wrv = ($urandom_range(0, 2) == 0);
               cur.wra = $urandom;
               cur.wrd = $urandom;
            end
            if (!(cur.rdv && !g_rd)) begin
               cur.rdv = ($urandom_range(0, 2) == 0);
               cur.rda = $urandom;
            end
            cur.gnt   = ($urandom_range(0, 3) != 0);
            cur.rv    = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            cur.rdata = $urandom;
            cur.rst   = ($urandom_range(0, 199) != 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end
endmodule

// File: doc/ctx_mem_arbiter.md
# ctx_mem_arbiter

Sequential arbiter that shares one OBI-style data-memory port between the cv32e40p data interface and the RTOS unit's context-memory write and read channels. It replaces the combinational "core wins, ctx waits" gating in the simulation wrapper. It holds the selection stable until grant, tracks outstanding transactions in order, and routes each `rvalid` back to its issuer. A starvation counter bounds how long context save/restore can be blocked by core traffic.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 2: max granted-but-unanswered transactions (1..8).
- `STARVE_LIMIT`, 4: consecutive core grants allowed while ctx traffic waits (1..15).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `core_req_i` / `core_we_i` / `core_be_i[3:0]` / `core_addr_i[31:0]` / `core_wdata_i[31:0]` in: core data request.
- `core_gnt_o` out 1; `core_rvalid_o` out 1; `core_rdata_o` out 32: core handshake and response.
- `ctx_wr_valid_i` in 1; `ctx_wr_addr_i` in 32; `ctx_wr_data_i` in 32; `ctx_wr_ready_o` out 1: ctx write channel, fire = valid & ready.
- `ctx_rd_valid_i` in 1; `ctx_rd_addr_i` in 32; `ctx_rd_ready_o` out 1: ctx read request.
- `ctx_rd_resp_valid_o` out 1; `ctx_rd_resp_data_o` out 32: ctx read response.
- `mem_req_o` / `mem_we_o` / `mem_be_o[3:0]` / `mem_addr_o[31:0]` / `mem_wdata_o[31:0]` out: shared memory request.
- `mem_gnt_i` / `mem_rvalid_i` in 1; `mem_rdata_i` in 32: shared memory handshake and response.
- `busy_o` out 1: lock held or any transaction outstanding.
- `err_o` out 1: sticky; set when `rvalid` arrives with nothing outstanding.

## Operation
- Sources: CORE=0, WR=1, RD=2.
- Source mapping to the memory port:
  - WR drives `we=1`, `be=4'hF`.
  - RD drives `we=0`, `be=4'hF`, `wdata=0`.
- Selection in the unlocked state:
  - No request is issued when `cnt == MAX_OUTSTANDING`.
  - Otherwise CORE wins if `core_req_i` is high and (no ctx valid, or `starve < STARVE_LIMIT`).
  - Otherwise ctx wins. Between WR and RD, a round-robin pointer `rr` picks; `rr` flips after each ctx grant and resets to WR.
- Lock:
  - If `mem_req_o & ~mem_gnt_i`, register `lock=1` and `lock_src=sel`.
  - While locked, `sel=lock_src` and `mem_req_o` stays high with attributes taken from that source, regardless of other requests.
  - The lock clears on `mem_gnt_i`.
  - Requesters must hold their request until granted (OBI / valid-ready rule).
- Grants pass through combinationally: `core_gnt_o = mem_gnt_i & mem_req_o & sel==CORE`. `ctx_wr_ready_o` and `ctx_rd_ready_o` follow the same form for their sources.
- `starve` counter (4 bits):
  - +1 on a core grant while any ctx valid is high.
  - 0 on any ctx grant, or in a cycle with no ctx valid.
  - Saturates at `STARVE_LIMIT`.
- Outstanding FIFO: depth `MAX_OUTSTANDING`, 2-bit source IDs, in order.
  - Push on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i`.
  - Count `cnt` has width `$clog2(MAX_OUTSTANDING+1)`; simultaneous push and pop leaves `cnt` unchanged.
- Response routing by the popped head ID, combinational:
  - CORE: `core_rvalid_o=1`, `core_rdata_o=mem_rdata_i`.
  - RD: `ctx_rd_resp_valid_o=1`, `ctx_rd_resp_data_o=mem_rdata_i`.
  - WR: the response is absorbed.
- Stray `mem_rvalid_i` with `cnt==0`: `err_o` is set (sticky until reset), no pop, and no response output toggles.

## Timing
- All registers reset to 0: lock, `starve`, `rr`, FIFO pointers, `cnt`, `err_o`.
- Every output is 0 while `rst_ni=0`, since it derives from zero state and no grants or rvalids are passed through.
- Zero-cycle arbitration: a request in cycle N can be granted in cycle N. The response returns whenever `mem_rvalid_i` arrives, with zero added latency.
- Full FIFO: `mem_req_o=0` in that cycle even if `mem_rvalid_i` frees a slot. Issue resumes the next cycle.
- Reset mid-transaction drops the lock and FIFO contents. A later stray `rvalid` sets `err_o`.
- Grant and rvalid in the same cycle are legal. The pop uses the FIFO head before the push.

## Test plan
- Core alone: core read at `0x100`, `gnt` same cycle, `rvalid` after 2 cycles with `0xDEADBEEF` -> `core_gnt_o` same cycle, `core_rvalid_o=1` with `core_rdata_o=0xDEADBEEF`, `ctx_rd_resp_valid_o=0`.
- Ctx write: `ctx_wr_valid_i=1`, addr `0x2000`, data `0x55`, memory delays `gnt` 3 cycles -> `mem_req_o`, `mem_addr_o=0x2000`, `we=1`, `be=F` held stable 3 cycles; `ctx_wr_ready_o` only on the grant cycle; the later `rvalid` gives no response output.
- Starvation (`STARVE_LIMIT=4`): core requests every cycle, `ctx_rd_valid_i` high throughout -> exactly 4 core grants, then RD is granted; `starve` returns to 0.
- Lock: core requests, `gnt` withheld; `ctx_wr_valid_i` rises next cycle -> `mem_addr_o` stays at the core address until `gnt`, with no switch to WR.
- Ordering with `MAX_OUTSTANDING=2`: grant CORE then RD back-to-back; a third request is blocked (`mem_req_o=0`); `rvalid` `0xA` then `0xB` -> `core_rdata_o=0xA`, then `ctx_rd_resp_data_o=0xB`.
- Error: `mem_rvalid_i` pulse right after reset -> `err_o=1` stays high; no `rvalid` is forwarded.
